// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// Byte-addressed data-memory responder: one load/store at a time, response pulse LATENCY+1 edges after acceptance,
// no response backpressure; `DMEM_MISALIGN_EN makes misaligned H/HU/W legal (byte-wise with address wrap).
module data_mem_responder #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    alive, accept, commit;
  logic                    lat_write;
  logic [2:0]              lat_funct3;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [WIDTH-1:0]        lat_wdata;
  logic                    op_write;
  logic [2:0]              op_funct3;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [WIDTH-1:0]        op_wdata;
  logic                    op_legal, op_misaligned, op_err;
  int                      op_bytes;
  logic [7:0]              mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   byte_addr [NB];
  logic [WIDTH-1:0]        rd_word, ld_data;
  logic                    unused_addr_hi;

  assign unused_addr_hi = &{1'b0, req_addr[WIDTH-1:ADDR_WIDTH]};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = alive;
        if (req_valid && alive) begin
          accept  = 1'b1;
          cnt_nxt = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY = 0 the commit edge is the acceptance edge, so the live request is used.
  assign op_write  = (state == IDLE) ? req_write                   : lat_write;
  assign op_funct3 = (state == IDLE) ? req_funct3                  : lat_funct3;
  assign op_addr   = (state == IDLE) ? req_addr[ADDR_WIDTH-1:0]    : lat_addr;
  assign op_wdata  = (state == IDLE) ? req_wdata                   : lat_wdata;

  always_comb begin
    op_bytes = (op_funct3[1:0] == 2'b00) ? 1 : (op_funct3[1:0] == 2'b01) ? 2 : NB;
    if (op_write)
      op_legal = op_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      op_legal = op_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef DMEM_MISALIGN_EN
    op_misaligned = 1'b0;
`else
    op_misaligned = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                    ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
`endif
    op_err = !op_legal || op_misaligned;
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      byte_addr[i]      = op_addr + ADDR_WIDTH'(i);
      rd_word[8*i +: 8] = mem[byte_addr[i]];
    end
  end

  always_comb begin
    case (op_funct3)
      3'b000:  ld_data = {{(WIDTH-8){rd_word[7]}}, rd_word[7:0]};
      3'b001:  ld_data = {{(WIDTH-16){rd_word[15]}}, rd_word[15:0]};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {{(WIDTH-8){1'b0}}, rd_word[7:0]};
      3'b101:  ld_data = {{(WIDTH-16){1'b0}}, rd_word[15:0]};
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      alive      <= 1'b0;
      lat_write  <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      alive <= 1'b1;
      if (accept) begin
        lat_write  <= req_write;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr[ADDR_WIDTH-1:0];
        lat_wdata  <= req_wdata;
      end
      if (commit) begin
        resp_err   <= op_err;
        resp_rdata <= (op_write || op_err) ? '0 : ld_data;
      end
    end
  end

  // Array is deliberately not reset; reset only blocks commits via the state register.
  always_ff @(posedge clk) begin
    if (commit && op_write && !op_err) begin
      for (int i = 0; i < NB; i++) begin
        if (i < op_bytes) mem[byte_addr[i]] <= op_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// Bench for data_mem_responder: directed vector table, handshake/reset sequences, random ops vs byte-array model.
module tb_data_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_ready, resp_valid, resp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        z_req_valid, z_req_write, z_req_ready, z_resp_valid, z_resp_err;
  logic [2:0]  z_req_funct3;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  bit me;
  logic [7:0] ref_mem [65536];

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  data_mem_responder #(.WIDTH(32), .ADDR_WIDTH(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  data_mem_responder #(.WIDTH(32), .ADDR_WIDTH(16), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_funct3(z_req_funct3), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata),
    .resp_err(z_resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain byte array, little-endian, wrap at 64 KiB.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int size, a;
    logic legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err   = !legal;
`ifndef DMEM_MISALIGN_EN
    if ((addr % size) != 0) err = 1'b1;
`endif
    a  = int'(addr % 65536);
    rd = '0;
    if (err) return;
    if (w) begin
      for (int i = 0; i < size; i++) ref_mem[(a + i) % 65536] = 8'(wdata >> (8 * i));
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[(a + i) % 65536]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
    end
  endfunction

  function automatic void add(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] r, input logic e);
    tv.push_back('{w, f3, a, d, r, e});
  endfunction

  // Called and returns at posedge+1 with the DUT idle.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("ready_before_req", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 1;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("resp_latency", 32'(n), 32'(LAT + 1));
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  task automatic rand_op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd, mrd;
    logic er, mer;
    do_req(w, f3, a, d, rd, er);
    model(w, f3, a, d, mrd, mer);
    check("rand_rdata", rd, mrd);
    check("rand_err", 32'(er), 32'(mer));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, mrd, exp_rd;
    logic er, mer;
    int pulses;
`ifdef DMEM_MISALIGN_EN
    me = 1'b1;
`else
    me = 1'b0;
`endif
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    z_req_valid = 0; z_req_write = 0; z_req_funct3 = 0; z_req_addr = 0; z_req_wdata = 0;
    #1 rst = 1'b0;
    #11;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_z_req_ready", 32'(z_req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // LATENCY = 0: held request gives a response every second cycle.
    z_req_valid = 1; z_req_write = 1; z_req_funct3 = 3'd2; z_req_addr = 32'h10; z_req_wdata = 32'hA5A5_A5A5;
    for (int c = 0; c < 20; c++) begin
      check("lat0_ready", 32'(z_req_ready), 32'((c % 2) == 0));
      check("lat0_valid", 32'(z_resp_valid), 32'((c % 2) == 1));
      @(posedge clk); #1;
    end
    z_req_write = 0;
    @(posedge clk); #1;
    z_req_valid = 0;
    check("lat0_load_valid", 32'(z_resp_valid), 32'd1);
    check("lat0_load_rdata", z_resp_rdata, 32'hA5A5_A5A5);
    check("lat0_load_err", 32'(z_resp_err), 32'd0);

    add(1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    add(0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    add(0, 3'd0, 32'h103, 32'h0, 32'hFFFF_FFDE, 0);
    add(0, 3'd4, 32'h103, 32'h0, 32'h0000_00DE, 0);
    add(0, 3'd1, 32'h102, 32'h0, 32'hFFFF_DEAD, 0);
    add(0, 3'd5, 32'h100, 32'h0, 32'h0000_BEEF, 0);
    add(1, 3'd0, 32'h101, 32'hFFFF_FF55, 32'h0, 0);
    add(0, 3'd2, 32'h100, 32'h0, 32'hDEAD_55EF, 0);
    add(1, 3'd2, 32'h104, 32'h0, 32'h0, 0);
    add(0, 3'd2, 32'h1234_0100, 32'h0, 32'hDEAD_55EF, 0);
    add(0, 3'd3, 32'h100, 32'h0, 32'h0, 1);
    add(1, 3'd4, 32'h100, 32'hFFFF_FFFF, 32'h0, 1);
    add(0, 3'd2, 32'h100, 32'h0, 32'hDEAD_55EF, 0);
    add(0, 3'd2, 32'h102, 32'h0, me ? 32'h0000_DEAD : 32'h0, !me);
    add(1, 3'd2, 32'h102, 32'h1234_5678, 32'h0, !me);
    add(0, 3'd2, 32'h100, 32'h0, me ? 32'h5678_55EF : 32'hDEAD_55EF, 0);
    add(0, 3'd1, 32'h101, 32'h0, me ? 32'h0000_7855 : 32'h0, !me);
    add(1, 3'd2, 32'hFFFC, 32'hAABB_CCDD, 32'h0, 0);
    add(1, 3'd2, 32'h0, 32'h0, 32'h0, 0);
    add(1, 3'd2, 32'hFFFF, 32'h1122_3344, 32'h0, !me);
    add(0, 3'd4, 32'hFFFF, 32'h0, me ? 32'h44 : 32'hAA, 0);
    add(0, 3'd4, 32'h0, 32'h0, me ? 32'h33 : 32'h00, 0);
    add(0, 3'd1, 32'hFFFF, 32'h0, me ? 32'h3344 : 32'h0, !me);
    for (int i = 0; i < tv.size(); i++) begin
      do_req(tv[i].w, tv[i].f3, tv[i].addr, tv[i].wdata, rd, er);
      model(tv[i].w, tv[i].f3, tv[i].addr, tv[i].wdata, mrd, mer);
      check($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].err));
    end

    // Held req_valid: ready low for 3 cycles per request; address wiggle during WAIT has no effect.
    model(0, 3'd2, 32'h100, 32'h0, exp_rd, mer);
    req_valid = 1; req_write = 0; req_funct3 = 3'd2; req_addr = 32'h100;
    for (int c = 0; c < 12; c++) begin
      check("hold_ready", 32'(req_ready), 32'((c % 4) == 0));
      check("hold_valid", 32'(resp_valid), 32'((c % 4) == 3));
      if ((c % 4) == 3) check("hold_rdata", resp_rdata, exp_rd);
      if (c == 1) req_addr = 32'h200;
      if (c == 3) req_addr = 32'h100;
      @(posedge clk); #1;
    end
    req_valid = 0;

    // Reset during WAIT of a store drops it.
    do_req(1, 3'd2, 32'h200, 32'hCAFE_F00D, rd, er);
    model(1, 3'd2, 32'h200, 32'hCAFE_F00D, mrd, mer);
    do_req(0, 3'd2, 32'h200, 32'h0, rd, er);
    check("pre_rst_load", rd, 32'hCAFE_F00D);
    req_valid = 1; req_write = 1; req_funct3 = 3'd2; req_addr = 32'h200; req_wdata = 32'h0102_0304;
    @(posedge clk); #1;
    req_valid = 0;
    rst = 1'b0;
    #2;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_resp_rdata", resp_rdata, 32'd0);
    check("midrst_resp_err", 32'(resp_err), 32'd0);
    #1 rst = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    check("midrst_no_resp", 32'(pulses), 32'd0);
    do_req(0, 3'd2, 32'h200, 32'h0, rd, er);
    check("midrst_load_rdata", rd, 32'hCAFE_F00D);
    check("midrst_load_err", 32'(er), 32'd0);

    for (int a = 0; a < 64; a += 4) begin
      rand_op(1, 3'd2, 32'(a), $urandom);
      rand_op(1, 3'd2, 32'h0000_FFC0 + 32'(a), $urandom);
    end
    for (int k = 0; k < 200; k++) begin
      logic [15:0] base;
      base = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 60)) : 16'(16'hFFC0 + $urandom_range(0, 63));
      rand_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {16'($urandom), base}, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the processor's data-memory interface: accepts one load or store request at a time from the memory stage over a valid/ready handshake and services it after a fixed, configurable wait. It returns a single-cycle response with load data already sign- or zero-extended. It owns the byte-addressed data array, so the memory stage only drives requests and consumes responses.

## Interface
Parameters:
- WIDTH, 32, data and address width.
- ADDR_WIDTH, 16, byte-address bits actually decoded; the array holds 2^ADDR_WIDTH bytes.
- LATENCY, 2, wait cycles inserted between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  input  WIDTH  byte address.
- req_wdata  input  WIDTH  store data, with the low bytes used for SB/SH.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  request was rejected (misaligned or illegal funct3); valid only with resp_valid.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - req_ready = 1.
  - When req_valid && req_ready at an edge, latch write, funct3, addr and wdata, and load counter = LATENCY.
  - Go to WAIT if LATENCY > 0, else to RESP.
- **WAIT**
  - req_ready = 0.
  - Counter decrements each edge.
  - When the counter equals 1 at an edge, go to RESP.
- **RESP**
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - There is no backpressure on the response; the consumer must stall on it.
- Request inputs are ignored outside the acceptance edge, so later changes have no effect.
- Addressing:
  - Only addr[ADDR_WIDTH-1:0] is decoded; upper bits are ignored, so addresses wrap.
  - Byte order is little-endian.
- Loads:
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW returns the full word.
  - Data is sampled from the array on the edge entering RESP.
- Stores:
  - SB writes wdata[7:0], SH writes wdata[15:0], SW writes the full word.
  - The array is updated on the edge entering RESP.
  - resp_rdata = 0 for stores.
- Errors:
  - The following set resp_err = 1 and resp_rdata = 0, and the array is not modified:
    - funct3 not in {000, 001, 010, 100, 101} for loads.
    - funct3 not in {000, 001, 010} for stores.
    - Misalignment: H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0 (misalignment is subject to Configuration).
- Array contents are not reset.

## Timing
- Reset values while rst is low: req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, state = IDLE. req_ready rises on the first edge after rst releases.
- Acceptance at edge E0 puts resp_valid high in the cycle following edge E0 + LATENCY + 1 edges.
  - LATENCY = 0 gives the response in the cycle right after E0.
  - LATENCY = 2 gives it two cycles later than that.
- req_ready is low from E0 through the RESP cycle and high again in the cycle after RESP. Peak throughput is one request per LATENCY + 2 cycles.
- A load issued immediately after a store to the same address returns the stored data, because the store commits before the next acceptance.
- resp_rdata and resp_err are registered and hold their value after the RESP cycle until the next RESP.
- Reset asserted mid-operation:
  - Immediately forces IDLE and clears all outputs.
  - The outstanding request is dropped with no response.
  - A store whose commit edge has not yet occurred is not written.

## Configuration
- DMEM_MISALIGN_EN:
  - When defined, misaligned H/HU/W accesses are legal. They access consecutive bytes addr, addr+1, ... with wrap at 2^ADDR_WIDTH, and set resp_err = 0. Only illegal funct3 raises resp_err.
  - When undefined, misaligned accesses are errors as described under Operation.

## Test plan
- Parameters LATENCY = 2, ADDR_WIDTH = 16:
  - SW 0xDEADBEEF to 0x100, then LW 0x100 → resp_valid 3 cycles after each acceptance; the load returns 0xDEADBEEF with resp_err = 0.
  - After that store, LB 0x103 → 0xFFFFFFDE; LBU 0x103 → 0x000000DE; LH 0x102 → 0xFFFFDEAD; LHU 0x100 → 0x0000BEEF.
  - SB 0x55 to 0x101, then LW 0x100 → 0xDEAD55EF.
  - Handshake: hold req_valid = 1 continuously → req_ready low for 3 cycles after each acceptance, with exactly one resp_valid pulse per request. Changing req_addr during WAIT does not change the result.
- Misaligned LW 0x102 without DMEM_MISALIGN_EN → resp_err = 1, rdata 0. Misaligned SW to 0x102 leaves the word at 0x100 unchanged. With DMEM_MISALIGN_EN, SW 0x11223344 to 0x0FFFF writes 0x44 to 0xFFFF and 0x33 to 0x0000, with no error.
- LATENCY = 0: back-to-back requests give a response every 2nd cycle.
- Reset pulsed during WAIT of an SW to 0x200 → no resp_valid; a subsequent LW 0x200 returns the prior contents.
- Illegal load funct3 = 011 → resp_err = 1.
